// File: rtl/cgra_cfg_tile_responder.sv
// CGRA-side cfg endpoint: registers the cfg packet, forwards it down the column,
// commits hits into a local register file and returns reads two cycles later.

package cgra_cfg_pkg;
  localparam int unsigned CgraCfgAddrWidth = 32;
  localparam int unsigned CgraCfgDataWidth = 32;

  typedef struct packed {
    logic [CgraCfgAddrWidth-1:0] cfg_addr;
    logic [CgraCfgDataWidth-1:0] cfg_data;
    logic                        cfg_wr_en;
    logic                        cfg_rd_en;
  } cgra_cfg_t;
endpackage

module cgra_cfg_tile_responder
  import cgra_cfg_pkg::*;
#(
  // Address/data widths must match the packet type in cgra_cfg_pkg.
  parameter int unsigned CGRA_CFG_ADDR_WIDTH = CgraCfgAddrWidth,
  parameter int unsigned CGRA_CFG_DATA_WIDTH = CgraCfgDataWidth,
  parameter int unsigned TILE_ID_WIDTH       = 16,
  parameter int unsigned NUM_REGS            = 8
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [TILE_ID_WIDTH-1:0]                tile_id,
  input  cgra_cfg_t                               cfg_in,
  output cgra_cfg_t                               cfg_out,
  output logic [CGRA_CFG_DATA_WIDTH-1:0]          cfg_rd_data,
  output logic                                    cfg_rd_data_valid,
  output logic [NUM_REGS*CGRA_CFG_DATA_WIDTH-1:0] cfg_regs,
  output logic                                    cfg_err
);

  localparam int unsigned FeatWidth = CGRA_CFG_ADDR_WIDTH - TILE_ID_WIDTH - 8;
  // 9 bits so NUM_REGS = 256 compares correctly against the 8-bit index.
  localparam logic [8:0]  NumRegsCmp = 9'(NUM_REGS);

  cgra_cfg_t                                   s1_q, s1_d;
  logic [NUM_REGS-1:0][CGRA_CFG_DATA_WIDTH-1:0] regs_q, regs_d;
  logic [CGRA_CFG_DATA_WIDTH-1:0]              rd_data_q, rd_data_d;
  logic                                        rd_valid_q, rd_valid_d;
  logic                                        err_q, err_d;

  logic [TILE_ID_WIDTH-1:0] id;
  logic [7:0]               idx;
  logic [FeatWidth-1:0]     feat;
  logic                     hit, idx_ok, wr_hit, rd_hit;

  // Decode the registered packet.
  always_comb begin
    id     = s1_q.cfg_addr[TILE_ID_WIDTH-1:0];
    idx    = s1_q.cfg_addr[TILE_ID_WIDTH +: 8];
    feat   = s1_q.cfg_addr[CGRA_CFG_ADDR_WIDTH-1 -: FeatWidth];
    hit    = (id == tile_id) && (feat == '0);
    idx_ok = ({1'b0, idx} < NumRegsCmp);
    wr_hit = hit && s1_q.cfg_wr_en;
    // Write wins when both enables are set.
    rd_hit = hit && s1_q.cfg_rd_en && !s1_q.cfg_wr_en;
  end

  // Next-state: packet capture, register commit, read response, sticky error.
  always_comb begin
    s1_d       = cfg_in;
    regs_d     = regs_q;
    rd_data_d  = '0;
    rd_valid_d = rd_hit;
    err_d      = err_q;
    // Only in-range indices match, so out-of-range writes drop and reads return 0.
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == 8'(i)) begin
        if (wr_hit) regs_d[i] = s1_q.cfg_data;
        if (rd_hit) rd_data_d = regs_q[i];
      end
    end
    if (hit && s1_q.cfg_wr_en && s1_q.cfg_rd_en) err_d = 1'b1;
    if (hit && !idx_ok && (s1_q.cfg_wr_en || s1_q.cfg_rd_en)) err_d = 1'b1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      regs_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      regs_q     <= regs_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign cfg_out           = s1_q;
  assign cfg_regs          = regs_q;
  assign cfg_rd_data       = rd_data_q;
  assign cfg_rd_data_valid = rd_valid_q;
  assign cfg_err           = err_q;

endmodule
